// File: rtl/trace_dfd_pkg.sv
// rtl/trace_dfd_pkg.sv - shared types and frame sizing for the trace readout path (TRACE_PARITY_EN adds a parity bit)
package trace_dfd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOAD,
        SHIFT,
        FIN
    } tr_state_t;

    // trace_buffer read data appears one cycle after the rd pulse; WAIT covers it
    localparam int RD_LAT = 1;

    function automatic int frame_bits(input int fpay);
`ifdef TRACE_PARITY_EN
        return fpay + 1;
`else
        return fpay;
`endif
    endfunction

endpackage

// File: rtl/trace_shift_reg.sv
// rtl/trace_shift_reg.sv - LSB-first word serialiser with bit counter (TRACE_PARITY_EN appends odd parity)
module trace_shift_reg
    import trace_dfd_pkg::*;
#(
    parameter int Fpay = 32
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            load_i,
    input  logic [Fpay-1:0] data_i,
    input  logic            shift_i,
    output logic            bit_o,
    output logic            frame_done_o
);

    localparam int FRAME_BITS = frame_bits(Fpay);
    localparam int BC_W       = $clog2(FRAME_BITS + 1);

    logic [Fpay-1:0] sr_q;
    logic [BC_W-1:0] bit_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else if (load_i) begin
            sr_q      <= data_i;
            bit_cnt_q <= '0;
        end else if (shift_i) begin
            sr_q      <= sr_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

`ifdef TRACE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            par_q <= 1'b0;
        end else if (load_i) begin
            par_q <= ~^data_i;
        end
    end

    // once the data bits are exhausted the frame's last slot carries the parity
    assign bit_o = (bit_cnt_q == BC_W'(Fpay)) ? par_q : sr_q[0];
`else
    assign bit_o = sr_q[0];
`endif

    assign frame_done_o = shift_i && (bit_cnt_q == BC_W'(FRAME_BITS - 1));

endmodule

// File: rtl/trace_readout.sv
// rtl/trace_readout.sv - pops N trace words and serialises them to the JTAG scan path (TRACE_PARITY_EN adds parity bit)
module trace_readout
    import trace_dfd_pkg::*;
#(
    parameter int Fpay  = 32,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             abort,
    output logic             tb_rd,
    input  logic [Fpay-1:0]  tb_dout,
    input  logic             shift_en,
    output logic             tdo,
    output logic             tdo_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_left
);

    tr_state_t        state_q, state_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic             sr_load, sr_shift, sr_bit, frame_done;

    assign sr_load  = (state_q == LOAD);
    assign sr_shift = (state_q == SHIFT) && shift_en && !abort;

    trace_shift_reg #(
        .Fpay(Fpay)
    ) u_shift (
        .clk_i       (clk),
        .resetn_i    (reset),
        .load_i      (sr_load),
        .data_i      (tb_dout),
        .shift_i     (sr_shift),
        .bit_o       (sr_bit),
        .frame_done_o(frame_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        tb_rd        = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d      = REQ;
                        words_left_d = num_words;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            REQ: begin
                tb_rd   = 1'b1;
                state_d = WAIT;
            end
            WAIT:  state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (frame_done) begin
                    if (words_left_q != '0) begin
                        words_left_d = words_left_q - 1'b1;
                    end
                    state_d = (words_left_q > CNT_W'(1)) ? REQ : FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort wins over everything else, including a pending done
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            words_left_d = '0;
            tb_rd        = 1'b0;
            done         = 1'b0;
        end
    end

    assign tdo_valid  = (state_q == SHIFT);
    assign tdo        = tdo_valid && sr_bit;
    assign busy       = (state_q != IDLE);
    assign words_left = words_left_q;

endmodule

// File: tb/tb_trace_readout.sv
// tb/tb_trace_readout.sv - directed self-checking bench for trace_readout
module tb_trace_readout;

`ifdef TRACE_PARITY_EN
    localparam int FB = 33;
`else
    localparam int FB = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  num_words = '0;
    logic        abort = 1'b0;
    logic        tb_rd;
    logic [31:0] tb_dout = '0;
    logic        shift_en = 1'b0;
    logic        tdo, tdo_valid, busy, done;
    logic [9:0]  words_left;

    trace_readout dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .tb_rd     (tb_rd),
        .tb_dout   (tb_dout),
        .shift_en  (shift_en),
        .tdo       (tdo),
        .tdo_valid (tdo_valid),
        .busy      (busy),
        .done      (done),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    int          rd_ptr = 0;
    int          rd_n = 0;

    always @(posedge clk) begin
        if (tb_rd) begin
            tb_dout <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
            rd_n    <= rd_n + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic       cap [0:255];
    logic [9:0] wl_at [0:7];
    int cap_n, done_n, done_cyc, last_cyc, first_val, last_val, val_n;

    function automatic logic [31:0] get_word(input int k);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = cap[k*FB + i];
        return w;
    endfunction

    task automatic do_start(input logic [9:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_dump(input string tag, input int period, input int limit);
        int cyc;
        cap_n = 0; done_n = 0; done_cyc = -1; last_cyc = -1;
        first_val = -1; last_val = -1; val_n = 0;
        for (cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            shift_en = (period <= 1) ? 1'b1 : ((cyc % period) == period - 1);
            if (tdo_valid) begin
                val_n++;
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                if (shift_en) begin
                    if (cap_n % FB == 0) wl_at[cap_n / FB] = words_left;
                    cap[cap_n] = tdo;
                    cap_n++;
                    last_cyc = cyc;
                end
            end
            if (!busy && cyc > 0) break;
        end
        shift_en = 1'b0;
        chk({tag, "_timeout_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, k;
        logic seen_done;

        mem[0] = 32'h0000_0001; mem[1] = 32'h8000_0000; mem[2] = 32'hA5A5_A5A5;
        mem[3] = 32'h1111_1111; mem[4] = 32'h2222_2222; mem[5] = 32'h3333_3333;
        mem[6] = 32'h0F0F_1234; mem[7] = 32'h0000_0003; mem[8] = 32'h0000_0001;
        for (int i = 9; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {tb_rd, tdo, tdo_valid, busy, done}, 0);
        chk("reset_words_left", words_left, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // two words, shift_en held high
        rd0 = rd_n;
        do_start(2);
        run_dump("t1", 1, 400);
        chk("t1_word0", get_word(0), 32'h0000_0001);
        chk("t1_word1", get_word(1), 32'h8000_0000);
        chk("t1_bits", cap_n, 2*FB);
        chk("t1_rd_count", rd_n - rd0, 2);
        chk("t1_done_count", done_n, 1);
        chk("t1_done_time", done_cyc, last_cyc + 1);
        chk("t1_wl_word0", wl_at[0], 2);
        chk("t1_wl_word1", wl_at[1], 1);
        chk("t1_wl_end", words_left, 0);

        // zero-length dump
        rd0 = rd_n;
        do_start(0);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 1);
        @(negedge clk);
        chk("t2_done_after", done, 0);
        chk("t2_busy_after", busy, 0);
        chk("t2_rd_count", rd_n - rd0, 0);

        // slow strobes, one word
        do_start(1);
        run_dump("t3", 3, 600);
        chk("t3_word", get_word(0), 32'hA5A5_A5A5);
        chk("t3_bits", cap_n, FB);
        chk("t3_valid_contig", val_n, last_val - first_val + 1);
        chk("t3_done_count", done_n, 1);

        // abort after 10 bits of the first of three words
        rd0 = rd_n;
        do_start(3);
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            shift_en = 1'b1;
            if (k == 10) begin
                abort = 1'b1;
                break;
            end
            if (tdo_valid) k++;
        end
        @(posedge clk);
        #1 abort = 1'b0;
        shift_en = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_words_left", words_left, 0);
        chk("t4_tdo_valid", tdo_valid, 0);
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("t4_no_done", seen_done, 0);
        chk("t4_rd_count", rd_n - rd0, 1);
        do_start(1);
        run_dump("t4b", 1, 200);
        chk("t4_next_word", get_word(0), 32'h2222_2222);

        // reset mid-SHIFT, start held through reset and accepted on release
        do_start(1);
        k = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            shift_en = 1'b1;
            if (tdo_valid) k++;
            if (k == 5) break;
        end
        @(negedge clk);
        shift_en  = 1'b0;
        reset     = 1'b0;
        start     = 1'b1;
        num_words = 1;
        @(negedge clk);
        chk("t5_reset_outputs", {tb_rd, tdo, tdo_valid, busy, done}, 0);
        chk("t5_reset_wl", words_left, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t5_accept_busy", busy, 1);
        chk("t5_accept_rd", tb_rd, 1);
        run_dump("t5", 1, 200);
        chk("t5_word", get_word(0), 32'h0F0F_1234);

`ifdef TRACE_PARITY_EN
        do_start(2);
        run_dump("t6", 1, 400);
        chk("t6_bits", cap_n, 66);
        chk("t6_word0", get_word(0), 32'h0000_0003);
        chk("t6_par0", cap[32], 1'b1);
        chk("t6_word1", get_word(1), 32'h0000_0001);
        chk("t6_par1", cap[65], 1'b0);
        chk("t6_done_time", done_cyc, last_cyc + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
